// File: rtl/xor_share_arb.sv
// Round-robin arbiter sharing one XOR unit among NREQ requesters.
// One grant per cycle; the registered result is returned with the winner's index.
module xor_share_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [ID_W-1:0]       res_id,
  output logic [CNT_W-1:0]      done_cnt
);

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             can_acc;
  logic             grant_vld;
  logic             grant_go;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] xor_all [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_xor
    assign xor_all[gi] = req_a[gi*WIDTH +: WIDTH] ^ req_b[gi*WIDTH +: WIDTH];
  end

  // Scan starting just after the last winner, wrapping modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_vld && req_valid[(int'(last_q) + k) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(last_q) + k) % NREQ);
      end
    end
  end

  assign can_acc  = !res_valid_q || res_ready;
  assign grant_go = can_acc && grant_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (grant_go) req_ready[grant_idx] = 1'b1;
  end

  // A transfer alone empties the slot; a grant in the same cycle refills it.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    last_d      = last_q;
    done_cnt_d  = done_cnt_q;
    if (res_valid_q && res_ready) begin
      done_cnt_d  = done_cnt_q + CNT_W'(1);
      res_valid_d = 1'b0;
    end
    if (grant_go) begin
      res_valid_d = 1'b1;
      res_data_d  = xor_all[grant_idx];
      res_id_d    = grant_idx;
      last_d      = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      last_q      <= ID_W'(NREQ - 1);
      done_cnt_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      last_q      <= last_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_xor_share_arb.sv
// Scoreboard bench for xor_share_arb: driver predicts grants and queues results,
// an independent monitor checks every presented result and the transfer counter.
module tb_xor_share_arb;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           res_valid, res_ready;
  logic [W-1:0]   res_data;
  logic [IDW-1:0] res_id;
  logic [CW-1:0]  done_cnt;

  xor_share_arb #(.WIDTH(W), .NREQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           id;
  } res_t;

  res_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         last_m = N - 1;
  bit         full_m = 1'b0;
  int         xfers  = 0;
  bit         mon_en = 1'b0;
  logic [N-1:0] v_v;
  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];
  logic       rdy_v, rst_v;
  int         g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first valid requester after the previous winner, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(output int gnt);
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst       = rst_v;
    req_valid = v_v;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
    end
    res_ready = rdy_v;
    #1;
    gnt = (!rst_v && (!full_m || rdy_v)) ? pick(v_v, last_m) : -1;
    exp_rdy = '0;
    if (gnt >= 0) exp_rdy[gnt] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst_v) begin
      q.delete();
      full_m = 1'b0;
      last_m = N - 1;
      xfers  = 0;
    end else if (gnt >= 0) begin
      q.push_back('{d: a_v[gnt] ^ b_v[gnt], id: gnt});
      full_m = 1'b1;
      last_m = gnt;
    end else if (full_m && rdy_v) begin
      full_m = 1'b0;
    end
  endtask

  task automatic refresh(input int i);
    a_v[i] = W'($urandom);
    b_v[i] = W'($urandom);
  endtask

  // Monitor: samples after the driver has settled inputs for the cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("res_valid", 32'(res_valid), 32'(q.size() > 0));
        chk("done_cnt", 32'(done_cnt), 32'(xfers % (1 << CW)));
        if (res_valid && q.size() > 0) begin
          chk("res_data", 32'(res_data), 32'(q[0].d));
          chk("res_id", 32'(res_id), 32'(q[0].id));
          if (res_ready && !rst) begin
            $display("RESULT id=%0d data=%02h done_cnt=%0d", res_id, res_data, done_cnt);
            void'(q.pop_front());
            xfers++;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    for (int i = 0; i < N; i++) refresh(i);
    v_v = '0; rdy_v = 1'b0; rst_v = 1'b1;
    cycle(g);
    cycle(g);
    rst_v = 1'b0;
    mon_en = 1'b1;

    // Single request from requester 0: A5 ^ 3C.
    v_v = 4'b0001; a_v[0] = 8'hA5; b_v[0] = 8'h3C; rdy_v = 1'b1;
    cycle(g);
    v_v = '0;
    cycle(g);
    cycle(g);

    // All four requesting with res_ready held high.
    v_v = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      cycle(g);
      if (g >= 0) refresh(g);
    end

    // Backpressure for five cycles, then release.
    rdy_v = 1'b0;
    for (int c = 0; c < 5; c++) cycle(g);
    rdy_v = 1'b1;
    cycle(g);
    if (g >= 0) refresh(g);

    // Rotation: force last=2, then 1011 -> 3, then 0011 -> 0.
    v_v = 4'b0100; cycle(g);
    v_v = 4'b1011; cycle(g);
    v_v = 4'b0011; cycle(g);

    // Reset while holding a result under backpressure.
    v_v = 4'b1111; rdy_v = 1'b0;
    cycle(g); cycle(g);
    rst_v = 1'b1; cycle(g);
    rst_v = 1'b0; rdy_v = 1'b1;
    cycle(g);
    if (g >= 0) refresh(g);

    // Randomized traffic with withdrawals and random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v_v[i] && ($urandom % 2 == 0)) begin
          v_v[i] = 1'b1;
          refresh(i);
        end else if (v_v[i] && ($urandom % 16 == 0)) begin
          v_v[i] = 1'b0;
        end
      end
      rdy_v = ($urandom % 4) != 0;
      cycle(g);
      if (g >= 0) v_v[g] = 1'b0;
    end

    v_v = '0; rdy_v = 1'b1;
    for (int c = 0; c < 4; c++) cycle(g);
    @(negedge clk);
    #3;
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
